// File: rtl/a2d_arbiter.sv
// a2d_arbiter: shares one A2D converter between two requesters.
// Alternates grants on contention and tracks a timeout and overruns per requester.
module a2d_arbiter #(
    parameter int TMO_CYCLES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv0,
    input  logic        strt_cnv1,
    input  logic [2:0]  chnnl0,
    input  logic [2:0]  chnnl1,
    output logic        cnv_cmplt0,
    output logic        cnv_cmplt1,
    output logic [11:0] res0,
    output logic [11:0] res1,
    output logic        tmo0,
    output logic        tmo1,
    output logic [1:0]  ovr,
    input  logic        clr_ovr,
    output logic        a2d_strt_cnv,
    output logic [2:0]  a2d_chnnl,
    input  logic        a2d_cnv_cmplt,
    input  logic [11:0] a2d_res
);

    localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           pend_q, pend_d;
    logic [1:0][2:0]      ch_q, ch_d;
    logic                 gnt_q, gnt_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0][11:0]     res_q, res_d;
    logic [1:0]           ovr_q, ovr_d;
    logic [2:0]           chnnl_q, chnnl_d;
    logic                 strt_q, strt_d;
    logic [1:0]           cmplt_q, cmplt_d;
    logic [1:0]           tmo_q, tmo_d;

    logic [1:0]           req;
    logic [1:0][2:0]      req_ch;

    assign req    = {strt_cnv1, strt_cnv0};
    assign req_ch = {chnnl1, chnnl0};

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ch_d    = ch_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovr_d   = clr_ovr ? 2'b00 : ovr_q;
        chnnl_d = chnnl_q;
        strt_d  = 1'b0;
        cmplt_d = 2'b00;
        tmo_d   = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    // gnt_q holds the previous grant, so contention alternates
                    gnt_d   = (&pend_q) ? ~gnt_q : pend_q[1];
                    chnnl_d = ch_q[gnt_d];
                    strt_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (a2d_cnv_cmplt) begin
                    res_d[gnt_q]   = a2d_res;
                    cmplt_d[gnt_q] = 1'b1;
                    state_d        = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d[gnt_q]  = 1'b1;
                    pend_d[gnt_q] = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                pend_d[gnt_q] = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a new request from the requester being completed outranks its clear
        for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
                if (!pend_q[i] ||
                    (state_q == DONE && int'(gnt_q) == i)) begin
                    pend_d[i] = 1'b1;
                    ch_d[i]   = req_ch[i];
                end else begin
                    ovr_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 2'b00;
            ch_q    <= '0;
            gnt_q   <= 1'b1;
            cnt_q   <= '0;
            res_q   <= '0;
            ovr_q   <= 2'b00;
            chnnl_q <= 3'd0;
            strt_q  <= 1'b0;
            cmplt_q <= 2'b00;
            tmo_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovr_q   <= ovr_d;
            chnnl_q <= chnnl_d;
            strt_q  <= strt_d;
            cmplt_q <= cmplt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cnv_cmplt0   = cmplt_q[0];
    assign cnv_cmplt1   = cmplt_q[1];
    assign res0         = res_q[0];
    assign res1         = res_q[1];
    assign tmo0         = tmo_q[0];
    assign tmo1         = tmo_q[1];
    assign ovr          = ovr_q;
    assign a2d_strt_cnv = strt_q;
    assign a2d_chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: directed scenarios plus random traffic, checked every cycle
// against a timeline model (grant cycle, busy window, done/timeout instants).
`timescale 1ns/1ps
module tb_a2d_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv0 = 1'b0, strt_cnv1 = 1'b0;
    logic [2:0]  chnnl0 = 3'd0, chnnl1 = 3'd0;
    logic        cnv_cmplt0, cnv_cmplt1;
    logic [11:0] res0, res1;
    logic        tmo0, tmo1;
    logic [1:0]  ovr;
    logic        clr_ovr = 1'b0;
    logic        a2d_strt_cnv;
    logic [2:0]  a2d_chnnl;
    logic        a2d_cnv_cmplt = 1'b0;
    logic [11:0] a2d_res = 12'd0;

    always #5 clk = ~clk;

    a2d_arbiter #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .strt_cnv0(strt_cnv0), .strt_cnv1(strt_cnv1),
        .chnnl0(chnnl0), .chnnl1(chnnl1),
        .cnv_cmplt0(cnv_cmplt0), .cnv_cmplt1(cnv_cmplt1),
        .res0(res0), .res1(res1),
        .tmo0(tmo0), .tmo1(tmo1),
        .ovr(ovr), .clr_ovr(clr_ovr),
        .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl),
        .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res)
    );

    int t;
    int n_cmp = 0;
    int n_bad = 0;

    // reference model: request bookkeeping plus the timeline of one conversion
    logic [1:0]  m_pend;
    logic [2:0]  m_ch [2];
    logic [11:0] m_res [2];
    logic [1:0]  m_ovr;
    int          m_last, m_owner, m_busy, m_done, m_idle;
    bit          m_act;
    logic        e_strt;
    logic [2:0]  e_chn;
    logic [1:0]  e_cmp, e_tmo;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, t, a, e);
        end
    endtask

    task automatic model_reset();
        m_pend = 2'b00;
        m_ch[0] = 3'd0;  m_ch[1] = 3'd0;
        m_res[0] = 12'd0; m_res[1] = 12'd0;
        m_ovr = 2'b00;
        m_last = 1; m_owner = 0; m_busy = 0; m_done = -1; m_idle = 0;
        m_act = 1'b0;
        e_strt = 1'b0; e_chn = 3'd0; e_cmp = 2'b00; e_tmo = 2'b00;
    endtask

    task automatic model_step();
        logic [1:0] st, acc, clr;
        logic [2:0] rc [2];
        int g;
        st = {strt_cnv1, strt_cnv0};
        rc[0] = chnnl0; rc[1] = chnnl1;
        e_strt = 1'b0; e_cmp = 2'b00; e_tmo = 2'b00; clr = 2'b00;
        for (int i = 0; i < 2; i++)
            acc[i] = st[i] && (!m_pend[i] ||
                     (m_act && m_owner == i && t == m_done));
        if (m_act && t == m_done) begin
            clr[m_owner] = 1'b1; m_act = 1'b0; m_idle = t + 1;
        end else if (m_act && t >= m_busy) begin
            if (a2d_cnv_cmplt) begin
                m_res[m_owner] = a2d_res;
                e_cmp[m_owner] = 1'b1;
                m_done = t + 1;
            end else if (t == m_busy + TMO - 1) begin
                e_tmo[m_owner] = 1'b1; clr[m_owner] = 1'b1;
                m_act = 1'b0; m_idle = t + 1;
            end
        end else if (!m_act && t >= m_idle && m_pend != 2'b00) begin
            g = (m_pend == 2'b11) ? 1 - m_last : (m_pend[1] ? 1 : 0);
            m_last = g; m_owner = g;
            e_chn = m_ch[g]; e_strt = 1'b1;
            m_act = 1'b1; m_busy = t + 2; m_done = -1;
        end
        m_pend = m_pend & ~clr;
        if (clr_ovr) m_ovr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (st[i]) begin
                if (acc[i]) begin
                    m_pend[i] = 1'b1; m_ch[i] = rc[i];
                end else begin
                    m_ovr[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a2d_strt_cnv", 32'(a2d_strt_cnv), 32'(e_strt));
        chk("a2d_chnnl", 32'(a2d_chnnl), 32'(e_chn));
        chk("cnv_cmplt0", 32'(cnv_cmplt0), 32'(e_cmp[0]));
        chk("cnv_cmplt1", 32'(cnv_cmplt1), 32'(e_cmp[1]));
        chk("tmo0", 32'(tmo0), 32'(e_tmo[0]));
        chk("tmo1", 32'(tmo1), 32'(e_tmo[1]));
        chk("res0", 32'(res0), 32'(m_res[0]));
        chk("res1", 32'(res1), 32'(m_res[1]));
        chk("ovr", 32'(ovr), 32'(m_ovr));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        t++;
        compare_all();
        strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
        clr_ovr = 1'b0; a2d_cnv_cmplt = 1'b0;
        a2d_res = 12'($urandom);
    endtask

    task automatic run_to(input int c);
        while (t < c) cyc();
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_strt"}, 32'(a2d_strt_cnv), 0);
        chk({nm, "_chnnl"}, 32'(a2d_chnnl), 0);
        chk({nm, "_cmplt"}, 32'({cnv_cmplt1, cnv_cmplt0}), 0);
        chk({nm, "_tmo"}, 32'({tmo1, tmo0}), 0);
        chk({nm, "_res0"}, 32'(res0), 0);
        chk({nm, "_res1"}, 32'(res1), 0);
        chk({nm, "_ovr"}, 32'(ovr), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        strt_cnv0 = 1'b0; strt_cnv1 = 1'b0;
        clr_ovr = 1'b0; a2d_cnv_cmplt = 1'b0;
        #1;
        chk("rst_async_res0", 32'(res0), 0);
        chk("rst_async_strt", 32'(a2d_strt_cnv), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        t = 0;
        model_reset();
    endtask

    task automatic wait_issue();
        int k;
        k = 0;
        while (!a2d_strt_cnv && k < 40) begin
            cyc();
            k++;
        end
        chk("issue_seen", 32'(a2d_strt_cnv), 1);
    endtask

    task automatic serve(input logic [2:0] ch, input int who,
                         input logic [11:0] rv);
        wait_issue();
        chk("serve_chnnl", 32'(a2d_chnnl), 32'(ch));
        cyc();
        a2d_cnv_cmplt = 1'b1; a2d_res = rv;
        cyc();
        chk("serve_cmplt", 32'(who == 1 ? cnv_cmplt1 : cnv_cmplt0), 1);
        chk("serve_res", 32'(who == 1 ? res1 : res0), 32'(rv));
        cyc();
    endtask

    initial begin
        int s, tcy, nis;
        bit saw;
        t = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_checks("por");
        rst_n = 1'b1;

        // single request with fixed latencies
        run_to(10);
        strt_cnv0 = 1'b1; chnnl0 = 3'd3;
        cyc();
        chk("single_no_early", 32'(a2d_strt_cnv), 0);
        cyc();
        chk("single_strt_c12", 32'(a2d_strt_cnv), 1);
        chk("single_chnnl", 32'(a2d_chnnl), 3);
        run_to(25);
        a2d_cnv_cmplt = 1'b1; a2d_res = 12'hA5C;
        cyc();
        chk("single_cmplt_c26", 32'(cnv_cmplt0), 1);
        chk("single_res0", 32'(res0), 32'h A5C);
        cyc();
        chk("single_cmplt_one", 32'(cnv_cmplt0), 0);

        // re-request during DONE is accepted without overrun
        strt_cnv0 = 1'b1; chnnl0 = 3'd2;
        cyc();
        wait_issue();
        cyc();
        a2d_cnv_cmplt = 1'b1; a2d_res = 12'h123;
        cyc();
        chk("done_cmplt", 32'(cnv_cmplt0), 1);
        strt_cnv0 = 1'b1; chnnl0 = 3'd4;
        cyc();
        chk("done_req_no_ovr", 32'(ovr), 0);
        cyc();
        chk("done_req_issue", 32'(a2d_strt_cnv), 1);
        chk("done_req_chnnl", 32'(a2d_chnnl), 4);

        // timeout: no completion for this conversion
        s = t; tcy = -1; saw = 1'b0;
        for (int k = 0; k < 30 && tcy < 0; k++) begin
            cyc();
            if (cnv_cmplt0) saw = 1'b1;
            if (tmo0) tcy = t;
        end
        chk("tmo_cycle", 32'(tcy), 32'(s + 1 + TMO));
        chk("tmo_no_cmplt", 32'(saw), 0);
        chk("tmo_res0_kept", 32'(res0), 32'h123);
        strt_cnv0 = 1'b1; chnnl0 = 3'd7;
        cyc();
        cyc();
        chk("tmo_idle_issue", 32'(a2d_strt_cnv), 1);

        // completion in the last counted cycle beats timeout
        s = t;
        run_to(s + TMO);
        a2d_cnv_cmplt = 1'b1; a2d_res = 12'h7E1;
        cyc();
        chk("tie_cmplt", 32'(cnv_cmplt0), 1);
        chk("tie_no_tmo", 32'(tmo0), 0);
        chk("tie_res0", 32'(res0), 32'h7E1);
        cyc();

        // contention alternates, requester 0 first after reset
        do_reset();
        for (int r = 0; r < 2; r++) begin
            strt_cnv0 = 1'b1; chnnl0 = 3'd1;
            strt_cnv1 = 1'b1; chnnl1 = 3'd6;
            cyc();
            serve(3'd1, 0, 12'(12'h111 * (r + 1)));
            serve(3'd6, 1, 12'(12'h333 * (r + 1)));
        end

        // overrun on requester 1
        do_reset();
        nis = 0;
        strt_cnv1 = 1'b1; chnnl1 = 3'd2;
        cyc();
        nis += int'(a2d_strt_cnv);
        strt_cnv1 = 1'b1; chnnl1 = 3'd5;
        cyc();
        nis += int'(a2d_strt_cnv);
        strt_cnv1 = 1'b1;
        cyc();
        nis += int'(a2d_strt_cnv);
        chk("ovr_set", 32'(ovr), 32'h2);
        clr_ovr = 1'b1;
        cyc();
        chk("ovr_clr", 32'(ovr), 0);
        for (int k = 0; k < 24; k++) begin
            cyc();
            nis += int'(a2d_strt_cnv);
        end
        chk("ovr_one_issue", 32'(nis), 1);

        // clear and a drop in the same cycle leaves the bit set
        strt_cnv1 = 1'b1; chnnl1 = 3'd1;
        cyc();
        strt_cnv1 = 1'b1; clr_ovr = 1'b1;
        cyc();
        chk("ovr_drop_wins", 32'(ovr), 32'h2);

        // reset mid-BUSY, then a stale completion
        do_reset();
        strt_cnv0 = 1'b1; chnnl0 = 3'd5;
        cyc();
        wait_issue();
        cyc();
        cyc();
        do_reset();
        a2d_cnv_cmplt = 1'b1; a2d_res = 12'hFFF;
        cyc();
        chk("stale_no_cmplt", 32'(cnv_cmplt0), 0);
        chk("stale_res0", 32'(res0), 0);
        cyc();
        chk("stale_idle", 32'(a2d_strt_cnv), 0);

        // random traffic
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int k = 0; k < 1500; k++) begin
                strt_cnv0 = ($urandom_range(0, 6) == 0);
                strt_cnv1 = ($urandom_range(0, 6) == 0);
                chnnl0 = 3'($urandom);
                chnnl1 = 3'($urandom);
                clr_ovr = ($urandom_range(0, 31) == 0);
                a2d_cnv_cmplt = ($urandom_range(0, 11) == 0);
                a2d_res = 12'($urandom);
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
